// File: rtl/dsp_sched_pkg.sv
// Shared constants and state encoding for the DSP48A1 dot-product sequencer.
package dsp_sched_pkg;

    localparam int unsigned OPM_W = 8;

    // X/Z multiplexer selections as seen by the DSP48A1 post-adder
    localparam logic [OPM_W-1:0] OPM_CLR  = 8'h01;
    localparam logic [OPM_W-1:0] OPM_ACC  = 8'h09;
    localparam logic [OPM_W-1:0] OPM_HOLD = 8'h08;
    localparam logic [OPM_W-1:0] OPM_IDLE = 8'h00;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        STREAM,
        DRAIN,
        OUT
    } state_t;

    function automatic logic accepts_beats(input state_t s);
        return (s == IDLE) || (s == STREAM);
    endfunction

endpackage

// File: rtl/dsp48a1_dot_sched_if.sv
// Operand stream, DSP48A1 control/feedback and result stream of the sequencer.
interface dsp48a1_dot_sched_if #(
    parameter int unsigned WIDTH_2 = 18,
    parameter int unsigned WIDTH_4 = 48,
    parameter int unsigned CNT_W   = 16
);
    logic               s_valid;
    logic               s_ready;
    logic               s_last;
    logic [WIDTH_2-1:0] s_a;
    logic [WIDTH_2-1:0] s_b;

    logic [WIDTH_2-1:0] dsp_a;
    logic [WIDTH_2-1:0] dsp_b;
    logic [7:0]         dsp_opmode;
    logic               dsp_rst;
    logic [WIDTH_4-1:0] dsp_p;
    logic               dsp_carryout;

    logic               m_valid;
    logic               m_ready;
    logic [WIDTH_4-1:0] m_data;
    logic               m_carry;
    logic [CNT_W-1:0]   m_count;

    // Sequencer side
    modport master (
        input  s_valid, s_last, s_a, s_b, dsp_p, dsp_carryout, m_ready,
        output s_ready, dsp_a, dsp_b, dsp_opmode, dsp_rst,
               m_valid, m_data, m_carry, m_count
    );

    // Operand source, DSP slice and result consumer side
    modport slave (
        output s_valid, s_last, s_a, s_b, dsp_p, dsp_carryout, m_ready,
        input  s_ready, dsp_a, dsp_b, dsp_opmode, dsp_rst,
               m_valid, m_data, m_carry, m_count
    );

endinterface

// File: rtl/dsp_sched_pipe_tracker.sv
// Follows issued beats through the DSP pipeline and delays OPMODE so the
// slice's OPMODEREG output lines up with the M register.
module dsp_sched_pipe_tracker
    import dsp_sched_pkg::*;
#(
    parameter int unsigned LAT     = 3,
    parameter int unsigned OPM_DLY = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             issue_valid,
    input  logic             issue_last,
    input  logic [OPM_W-1:0] opm_in,
    output logic             tail_valid,
    output logic             tail_last,
    output logic [OPM_W-1:0] opm_out
);

    logic [LAT-1:0] vld_sr;
    logic [LAT-1:0] last_sr;

    // Concatenate-and-truncate keeps the shift legal for LAT == 1
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vld_sr  <= '0;
            last_sr <= '0;
        end else begin
            vld_sr  <= LAT'({vld_sr, issue_valid});
            last_sr <= LAT'({last_sr, issue_last});
        end
    end

    assign tail_valid = vld_sr[LAT-1];
    assign tail_last  = last_sr[LAT-1];

    generate
        if (OPM_DLY == 0) begin : g_opm_direct
            assign opm_out = opm_in;
        end else begin : g_opm_delay
            logic [OPM_DLY-1:0][OPM_W-1:0] opm_sr;

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    opm_sr <= '0;
                end else begin
                    opm_sr <= (OPM_DLY*OPM_W)'({opm_sr, opm_in});
                end
            end

            assign opm_out = opm_sr[OPM_DLY-1];
        end
    endgenerate

endmodule

// File: rtl/dsp48a1_dot_sched.sv
// Dot-product sequencer for a DSP48A1 slice (A1/B1/M/P/OPMODE registered).
// Optional beat counter on m_count: define DSP_SCHED_BEAT_COUNT_EN.
module dsp48a1_dot_sched
    import dsp_sched_pkg::*;
#(
    parameter int unsigned WIDTH_2 = 18,
    parameter int unsigned WIDTH_4 = 48,
    parameter int unsigned LAT     = 3,
    parameter int unsigned OPM_DLY = 1,
    parameter int unsigned CNT_W   = 16
) (
    input logic                  CLK,
    input logic                  RST_N,
    dsp48a1_dot_sched_if.master  bus
);

    state_t             state, state_n;
    logic               s_ready_q, s_ready_n;
    logic               dsp_rst_q, dsp_rst_n;
    logic [WIDTH_2-1:0] a_q, a_n;
    logic [WIDTH_2-1:0] b_q, b_n;
    logic [OPM_W-1:0]   opm_q, opm_n;
    logic               issue_valid_q, issue_valid_n;
    logic               issue_last_q, issue_last_n;
    logic               m_valid_q, m_valid_n;
    logic [WIDTH_4-1:0] m_data_q, m_data_n;
    logic               m_carry_q, m_carry_n;

    logic               tail_valid;
    logic               tail_last;
    logic [OPM_W-1:0]   opm_dly;
    logic               accept;

    assign accept = bus.s_valid & s_ready_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state         <= INIT;
            s_ready_q     <= 1'b0;
            dsp_rst_q     <= 1'b1;
            a_q           <= '0;
            b_q           <= '0;
            opm_q         <= OPM_IDLE;
            issue_valid_q <= 1'b0;
            issue_last_q  <= 1'b0;
            m_valid_q     <= 1'b0;
            m_data_q      <= '0;
            m_carry_q     <= 1'b0;
        end else begin
            state         <= state_n;
            s_ready_q     <= s_ready_n;
            dsp_rst_q     <= dsp_rst_n;
            a_q           <= a_n;
            b_q           <= b_n;
            opm_q         <= opm_n;
            issue_valid_q <= issue_valid_n;
            issue_last_q  <= issue_last_n;
            m_valid_q     <= m_valid_n;
            m_data_q      <= m_data_n;
            m_carry_q     <= m_carry_n;
        end
    end

    // Next state, DSP issue and result capture
    always_comb begin
        state_n       = state;
        a_n           = a_q;
        b_n           = b_q;
        opm_n         = OPM_IDLE;
        issue_valid_n = 1'b0;
        issue_last_n  = 1'b0;
        m_valid_n     = m_valid_q;
        m_data_n      = m_data_q;
        m_carry_n     = m_carry_q;

        case (state)
            INIT: state_n = IDLE;
            IDLE, STREAM: begin
                if (accept) begin
                    a_n           = bus.s_a;
                    b_n           = bus.s_b;
                    opm_n         = (state == IDLE) ? OPM_CLR : OPM_ACC;
                    issue_valid_n = 1'b1;
                    issue_last_n  = bus.s_last;
                    state_n       = bus.s_last ? DRAIN : STREAM;
                end else if (state == STREAM) begin
                    // Bubble: P keeps the running sum
                    a_n   = '0;
                    b_n   = '0;
                    opm_n = OPM_HOLD;
                end
            end
            DRAIN: begin
                a_n = '0;
                b_n = '0;
                if (tail_valid && tail_last) begin
                    m_valid_n = 1'b1;
                    m_data_n  = bus.dsp_p;
                    m_carry_n = bus.dsp_carryout;
                    state_n   = OUT;
                end
            end
            OUT: begin
                if (bus.m_ready) begin
                    m_valid_n = 1'b0;
                    state_n   = IDLE;
                end
            end
            default: state_n = INIT;
        endcase

        s_ready_n = accepts_beats(state_n);
        dsp_rst_n = (state_n == INIT);
    end

    dsp_sched_pipe_tracker #(
        .LAT     (LAT),
        .OPM_DLY (OPM_DLY)
    ) u_tracker (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .issue_valid (issue_valid_q),
        .issue_last  (issue_last_q),
        .opm_in      (opm_q),
        .tail_valid  (tail_valid),
        .tail_last   (tail_last),
        .opm_out     (opm_dly)
    );

`ifdef DSP_SCHED_BEAT_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [CNT_W-1:0] m_count_q, m_count_n;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q     <= '0;
            m_count_q <= '0;
        end else begin
            cnt_q     <= cnt_n;
            m_count_q <= m_count_n;
        end
    end

    // Saturating beat count, sampled together with P
    always_comb begin
        cnt_n     = cnt_q;
        m_count_n = m_count_q;
        if (accept) begin
            if (state == IDLE) begin
                cnt_n = CNT_W'(1);
            end else if (cnt_q != CNT_MAX) begin
                cnt_n = cnt_q + CNT_W'(1);
            end
        end
        if ((state == DRAIN) && tail_valid && tail_last) begin
            m_count_n = cnt_q;
        end
    end

    assign bus.m_count = m_count_q;
`else
    assign bus.m_count = CNT_W'(0);
`endif

    assign bus.s_ready    = s_ready_q;
    assign bus.dsp_a      = a_q;
    assign bus.dsp_b      = b_q;
    assign bus.dsp_opmode = opm_dly;
    assign bus.dsp_rst    = dsp_rst_q;
    assign bus.m_valid    = m_valid_q;
    assign bus.m_data     = m_data_q;
    assign bus.m_carry    = m_carry_q;

endmodule

// File: tb/tb_dsp48a1_dot_sched.sv
// Directed bench for dsp48a1_dot_sched with a behavioural DSP48A1 slice
// (A1/B1/M/P/OPMODE registered, synchronous reset).
module tb_dsp48a1_dot_sched;
    import dsp_sched_pkg::*;

    localparam int unsigned W2 = 18;
    localparam int unsigned W4 = 48;
    localparam int unsigned CW = 16;

    logic CLK = 1'b0;
    logic RST_N;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    dsp48a1_dot_sched_if #(.WIDTH_2(W2), .WIDTH_4(W4), .CNT_W(CW)) bus ();

    dsp48a1_dot_sched #(
        .WIDTH_2 (W2), .WIDTH_4 (W4), .LAT (3), .OPM_DLY (1), .CNT_W (CW)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    // Behavioural DSP48A1 slice
    logic signed [W2-1:0] a1, b1;
    logic signed [35:0]   m_r;
    logic [7:0]           opm_r;
    logic [W4-1:0]        p_r, x_mux, z_mux;
    logic                 co_r;

    always_comb begin
        x_mux = (opm_r[1:0] == 2'b01) ? {{(W4-36){m_r[35]}}, m_r} : '0;
        z_mux = (opm_r[3:2] == 2'b10) ? p_r : '0;
    end

    always @(posedge CLK) begin
        if (bus.dsp_rst) begin
            a1 <= '0; b1 <= '0; m_r <= '0; opm_r <= '0; p_r <= '0; co_r <= 1'b0;
        end else begin
            a1    <= bus.dsp_a;
            b1    <= bus.dsp_b;
            m_r   <= a1 * b1;
            opm_r <= bus.dsp_opmode;
            {co_r, p_r} <= {1'b0, x_mux} + {1'b0, z_mux};
        end
    end

    assign bus.dsp_p        = p_r;
    assign bus.dsp_carryout = co_r;

    function automatic logic [CW-1:0] exp_cnt(input int n);
`ifdef DSP_SCHED_BEAT_COUNT_EN
        return CW'(n);
`else
        return CW'(0 * n);
`endif
    endfunction

    task automatic idle_in();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.s_a     = '0;
        bus.s_b     = '0;
    endtask

    // Presents a beat at a negedge; returns at the negedge after acceptance
    task automatic send_beat(input int a, input int b, input logic last, output int acc);
        bus.s_a     = W2'(a);
        bus.s_b     = W2'(b);
        bus.s_last  = last;
        bus.s_valid = 1'b1;
        acc = -100;
        for (int i = 0; i < 20; i++) begin
            if (bus.s_ready === 1'b1) begin
                acc = cyc;
                @(negedge CLK);
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic wait_result(output int seen);
        seen = -1000;
        for (int i = 0; i < 40; i++) begin
            if (bus.m_valid === 1'b1) begin
                seen = cyc;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic take_result();
        bus.m_ready = 1'b1;
        @(negedge CLK);
        bus.m_ready = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        idle_in();
        bus.m_ready = 1'b0;
        repeat (2) @(negedge CLK);
        n_cmp++; if (bus.dsp_rst !== 1'b1) begin n_err++; $display("FAIL rst_dsp_rst got %0b want 1", bus.dsp_rst); end
        n_cmp++; if ({bus.s_ready, bus.m_valid} !== 2'b00) begin n_err++; $display("FAIL rst_ready_valid got %b want 00", {bus.s_ready, bus.m_valid}); end
        n_cmp++; if (bus.dsp_opmode !== 8'h00) begin n_err++; $display("FAIL rst_opmode got %h want 00", bus.dsp_opmode); end
        n_cmp++; if (bus.m_data !== '0) begin n_err++; $display("FAIL rst_m_data got %0d want 0", bus.m_data); end
        RST_N = 1'b1;
        #1;
        n_cmp++; if (bus.dsp_rst !== 1'b1) begin n_err++; $display("FAIL rel_dsp_rst_held got %0b want 1", bus.dsp_rst); end
        @(negedge CLK);
        n_cmp++; if (bus.dsp_rst !== 1'b0) begin n_err++; $display("FAIL rel_dsp_rst_drop got %0b want 0", bus.dsp_rst); end
        n_cmp++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL rel_s_ready got %0b want 1", bus.s_ready); end
        repeat (2) begin
            @(negedge CLK);
            n_cmp++; if ({bus.m_valid, bus.dsp_opmode} !== 9'h000) begin n_err++; $display("FAIL rel_idle got valid=%0b opm=%h want 0/00", bus.m_valid, bus.dsp_opmode); end
        end
    endtask

    task automatic test_back_to_back();
        int acc, seen;
        send_beat(2, 3, 1'b0, acc);
        send_beat(4, 5, 1'b1, acc);
        idle_in();
        wait_result(seen);
        n_cmp++; if (seen - acc !== 5) begin n_err++; $display("FAIL b2b_latency got %0d want 5", seen - acc); end
        n_cmp++; if (bus.m_data !== W4'(26)) begin n_err++; $display("FAIL b2b_data got %0d want 26", bus.m_data); end
        n_cmp++; if (bus.m_carry !== 1'b0) begin n_err++; $display("FAIL b2b_carry got %0b want 0", bus.m_carry); end
        n_cmp++; if (bus.m_count !== exp_cnt(2)) begin n_err++; $display("FAIL b2b_count got %0d want %0d", bus.m_count, exp_cnt(2)); end
        take_result();
        n_cmp++; if ({bus.m_valid, bus.s_ready} !== 2'b01) begin n_err++; $display("FAIL b2b_release got %b want 01", {bus.m_valid, bus.s_ready}); end
    endtask

    task automatic test_single();
        int acc, seen;
        send_beat(7, 9, 1'b1, acc);
        idle_in();
        wait_result(seen);
        n_cmp++; if (seen - acc !== 5) begin n_err++; $display("FAIL single_latency got %0d want 5", seen - acc); end
        n_cmp++; if (bus.m_data !== W4'(63)) begin n_err++; $display("FAIL single_data got %0d want 63", bus.m_data); end
        n_cmp++; if (bus.m_count !== exp_cnt(1)) begin n_err++; $display("FAIL single_count got %0d want %0d", bus.m_count, exp_cnt(1)); end
        take_result();
        send_beat(1, 1, 1'b1, acc);
        idle_in();
        wait_result(seen);
        n_cmp++; if (bus.m_data !== W4'(1)) begin n_err++; $display("FAIL clear_data got %0d want 1", bus.m_data); end
        take_result();
    endtask

    task automatic test_gap();
        int acc, seen;
        send_beat(3, 3, 1'b0, acc);
        idle_in();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (i > 0) begin
                n_cmp++; if (bus.dsp_opmode !== OPM_HOLD) begin n_err++; $display("FAIL gap_opmode[%0d] got %h want 08", i, bus.dsp_opmode); end
                n_cmp++; if ({bus.dsp_a, bus.dsp_b} !== '0) begin n_err++; $display("FAIL gap_operands[%0d] got %0d,%0d want 0,0", i, bus.dsp_a, bus.dsp_b); end
            end
        end
        send_beat(2, 2, 1'b1, acc);
        idle_in();
        wait_result(seen);
        n_cmp++; if (seen - acc !== 5) begin n_err++; $display("FAIL gap_latency got %0d want 5", seen - acc); end
        n_cmp++; if (bus.m_data !== W4'(13)) begin n_err++; $display("FAIL gap_data got %0d want 13", bus.m_data); end
        n_cmp++; if (bus.m_count !== exp_cnt(2)) begin n_err++; $display("FAIL gap_count got %0d want %0d", bus.m_count, exp_cnt(2)); end
        take_result();
    endtask

    task automatic test_backpressure();
        int acc, seen;
        send_beat(6, 7, 1'b1, acc);
        idle_in();
        wait_result(seen);
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if ({bus.m_valid, bus.s_ready, bus.m_data} !== {1'b1, 1'b0, W4'(42)}) begin
                n_err++;
                $display("FAIL hold[%0d] got valid=%0b ready=%0b data=%0d want 1/0/42", i, bus.m_valid, bus.s_ready, bus.m_data);
            end
            @(negedge CLK);
        end
        take_result();
        n_cmp++; if ({bus.m_valid, bus.s_ready} !== 2'b01) begin n_err++; $display("FAIL hold_release got %b want 01", {bus.m_valid, bus.s_ready}); end
    endtask

    task automatic test_reset_mid();
        int acc, seen;
        send_beat(1, 2, 1'b0, acc);
        send_beat(3, 4, 1'b0, acc);
        idle_in();
        RST_N = 1'b0;
        #1;
        n_cmp++; if ({bus.dsp_rst, bus.s_ready} !== 2'b10) begin n_err++; $display("FAIL mid_rst got %b want 10", {bus.dsp_rst, bus.s_ready}); end
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        n_cmp++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL mid_restart got %0b want 1", bus.s_ready); end
        send_beat(5, 5, 1'b1, acc);
        idle_in();
        wait_result(seen);
        n_cmp++; if (bus.m_data !== W4'(25)) begin n_err++; $display("FAIL mid_data got %0d want 25", bus.m_data); end
        n_cmp++; if (bus.m_count !== exp_cnt(1)) begin n_err++; $display("FAIL mid_count got %0d want %0d", bus.m_count, exp_cnt(1)); end
        take_result();
        for (int k = 1; k <= 4; k++) send_beat(k, k, (k == 4), acc);
        idle_in();
        wait_result(seen);
        n_cmp++; if (seen - acc !== 5) begin n_err++; $display("FAIL four_latency got %0d want 5", seen - acc); end
        n_cmp++; if (bus.m_data !== W4'(30)) begin n_err++; $display("FAIL four_data got %0d want 30", bus.m_data); end
        n_cmp++; if (bus.m_count !== exp_cnt(4)) begin n_err++; $display("FAIL four_count got %0d want %0d", bus.m_count, exp_cnt(4)); end
        take_result();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_single();
        test_gap();
        test_backpressure();
        test_reset_mid();
        repeat (2) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
